// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with stall/step-gated consumption and branch redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse_en,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [3:0]         rsrc,
  output logic [3:0]         rdest,
  output logic [31:0]        instr_count
);
  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc;
  logic fire, consume;
  // next state: an ack only counts in REQ, a step only counts in VALID
  always_comb begin
    fire = state == REQ && imem_ack;
    consume = state == VALID && pulse_en && !stall;
    state_nxt = state == IDLE ? REQ : fire ? VALID : consume ? REQ : state;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  // capture returned instruction, advance or redirect fetch address, count consumed instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pc <= '0;
      instr <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else if (fire) begin
      instr <= imem_rdata;
      pc <= fetch_pc;
      instr_valid <= 1'b1;
      fetch_pc <= fetch_pc + 32'd1;
    end else if (consume) begin
      instr_valid <= 1'b0;
      instr_count <= instr_count + 32'd1;
      fetch_pc <= branch_taken ? branch_target : fetch_pc;
    end
  end
  assign imem_req = state == REQ;
  assign imem_addr = fetch_pc;
  assign rsrc = instr[3:0];
  assign rdest = instr[11:8];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a cycle-level reference model and literal spot checks
module tb_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, pulse_en = 1'b0, stall = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target = '0;
  logic [15:0] imem_rdata = '0;
  logic imem_req, instr_valid, imem_req1, instr_valid1;
  logic [31:0] imem_addr, pc, instr_count, imem_addr1, pc1, instr_count1;
  logic [15:0] instr, instr1;
  logic [3:0] rsrc, rdest, rsrc1, rdest1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pulse_en(pulse_en), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .instr_valid(instr_valid), .rsrc(rsrc),
    .rdest(rdest), .instr_count(instr_count)
  );

  // same stimulus, fetch starting at the top of the address space
  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset), .pulse_en(pulse_en), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc1), .instr(instr1), .instr_valid(instr_valid1), .rsrc(rsrc1),
    .rdest(rdest1), .instr_count(instr_count1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: fresh = first cycle out of reset (no request yet); a request is pending whenever nothing is held
  logic m_known = 1'b0, m_fresh = 1'b0, m_valid = 1'b0;
  logic [31:0] m_fpc = '0, m_pc = '0, m_cnt = '0;
  logic [15:0] m_instr = '0;
  always @(posedge clk) begin
    if (reset) begin
      m_known <= 1'b1; m_fresh <= 1'b1; m_valid <= 1'b0;
      m_fpc <= 32'h0; m_pc <= '0; m_instr <= '0; m_cnt <= '0;
    end else if (m_fresh) m_fresh <= 1'b0;
    else if (!m_valid) begin
      if (imem_ack) begin
        m_instr <= imem_rdata; m_pc <= m_fpc; m_valid <= 1'b1; m_fpc <= m_fpc + 1;
      end
    end else if (pulse_en && !stall) begin
      m_valid <= 1'b0; m_cnt <= m_cnt + 1;
      if (branch_taken) m_fpc <= branch_target;
    end
  end

  always @(negedge clk) if (m_known) begin
    chk("m_imem_req", imem_req, !m_fresh && !m_valid);
    chk("m_imem_addr", imem_addr, m_fpc);
    chk("m_instr_valid", instr_valid, m_valid);
    chk("m_pc", pc, m_pc);
    chk("m_instr", instr, m_instr);
    chk("m_rsrc", rsrc, m_instr[3:0]);
    chk("m_rdest", rdest, m_instr[11:8]);
    chk("m_instr_count", instr_count, m_cnt);
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    step(); step();
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_addr_wrap", imem_addr1, 32'hFFFF_FFFF);
    // zero-wait fetch
    reset = 0; imem_ack = 1; imem_rdata = 16'h1A2B;
    step();
    chk("zw_req", imem_req, 1);
    chk("zw_addr", imem_addr, 0);
    chk("zw_novalid", instr_valid, 0);
    step();
    chk("zw_instr", instr, 16'h1A2B);
    chk("zw_pc", pc, 0);
    chk("zw_rsrc", rsrc, 4'hB);
    chk("zw_rdest", rdest, 4'hA);
    chk("zw_valid", instr_valid, 1);
    chk("wrap_pc0", pc1, 32'hFFFF_FFFF);
    // stall for 5 cycles, then release
    imem_ack = 0; stall = 1; pulse_en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_instr", instr, 16'h1A2B);
      chk("st_count", instr_count, 0);
    end
    stall = 0;
    step();
    chk("rel_count", instr_count, 1);
    chk("rel_valid", instr_valid, 0);
    chk("rel_addr", imem_addr, 1);
    chk("wrap_addr", imem_addr1, 0);
    // ack delayed 3 cycles
    pulse_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dl_req", imem_req, 1);
      chk("dl_addr", imem_addr, 1);
      chk("dl_novalid", instr_valid, 0);
    end
    imem_ack = 1; imem_rdata = 16'h55AA;
    step();
    chk("dl_instr", instr, 16'h55AA);
    chk("dl_pc", pc, 1);
    chk("wrap_pc1", pc1, 0);
    // branch to 0x10, with a branch pulse during REQ that must be ignored
    imem_ack = 0; pulse_en = 1; branch_taken = 1; branch_target = 32'h10;
    step();
    chk("br1_addr", imem_addr, 32'h10);
    branch_target = 32'h300;
    step();
    chk("brq_addr", imem_addr, 32'h10);
    imem_ack = 1; imem_rdata = 16'h1234; branch_taken = 0; pulse_en = 0;
    step();
    chk("br1_pc", pc, 32'h10);
    imem_ack = 0; pulse_en = 1; branch_taken = 1; branch_target = 32'h200;
    step();
    chk("br2_addr", imem_addr, 32'h200);
    branch_target = 32'h999; imem_ack = 1; imem_rdata = 16'hBEEF; pulse_en = 0;
    step();
    chk("br2_pc", pc, 32'h200);
    // branch while stalled is ignored
    imem_ack = 0; pulse_en = 1; stall = 1; branch_target = 32'h777;
    step();
    chk("brs_pc", pc, 32'h200);
    stall = 0; branch_taken = 0;
    step();
    chk("brs_addr", imem_addr, 32'h201);
    chk("brs_count", instr_count, 4);
    // reset mid-REQ, ack arrives right after
    reset = 1;
    step();
    chk("mr_req", imem_req, 0);
    reset = 0; imem_ack = 1; imem_rdata = 16'hDEAD;
    step();
    chk("mr_novalid", instr_valid, 0);
    chk("mr_req2", imem_req, 1);
    chk("mr_addr", imem_addr, 0);
    imem_ack = 0;
    step();
    chk("mr_count", instr_count, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
